// File: rtl/sid_bus_master.sv
// sid_bus_master: bus initiator for the SID register interface.
// Commands (rw, addr, data) are queued in a small FIFO and replayed as
// SETUP / STROBE / HOLD bus cycles on CEb, RWb, reg_addr and bus_out.
// Optional feature macro: SID_BUS_READ_EN. When defined, read commands run
// a bus cycle and return the captured bus_in value on rsp_valid/rsp_data.
// When undefined, read commands are popped and dropped without a bus cycle.
module sid_bus_master #(
    parameter int DEPTH  = 4,
    parameter int SETUP  = 1,
    parameter int STROBE = 2,
    parameter int HOLD   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [5:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       RWb,
    output logic       CEb,
    output logic [5:0] reg_addr,
    output logic [7:0] bus_out,
    input  logic [7:0] bus_in
);

    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PMAX = (SETUP > STROBE) ? ((SETUP > HOLD) ? SETUP : HOLD)
                                           : ((STROBE > HOLD) ? STROBE : HOLD);
    localparam int CW   = $clog2(PMAX + 1);

    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_ZERO = (AW + 1)'(0);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);
    localparam logic [CW-1:0] PH_SETUP = CW'(SETUP);
    localparam logic [CW-1:0] PH_STROB = CW'(STROBE);
    localparam logic [CW-1:0] PH_HOLD  = CW'(HOLD);
    localparam logic [CW-1:0] PH_ONE   = CW'(1);
    localparam logic [CW-1:0] PH_ZERO  = CW'(0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_STROB = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // ---------------- command FIFO ----------------
    logic [14:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_s, pop_s, empty_s, full_s;
    logic [14:0]   head_s;
    logic          head_skip_s;

    assign full_s  = (count_q == CNT_FULL);
    assign empty_s = (count_q == CNT_ZERO);
    assign push_s  = cmd_valid && !full_s;
    assign head_s  = mem_q[rd_ptr_q];

`ifdef SID_BUS_READ_EN
    assign head_skip_s = 1'b0;
`else
    // Reads are dropped at the head of the queue when read support is off.
    assign head_skip_s = head_s[14];
`endif

    // FIFO pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // FIFO pointer and occupancy registers; reset flushes the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            count_q  <= CNT_ZERO;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; stale entries are harmless because the pointers gate them.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {cmd_rw, cmd_addr, cmd_data};
        end
    end

    // ---------------- bus cycle sequencer ----------------
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rwb_q, rwb_d;
    logic          ceb_q, ceb_d;
    logic [5:0]    addr_q, addr_d;
    logic [7:0]    bus_out_q, bus_out_d;
    logic          launch_s;
`ifdef SID_BUS_READ_EN
    logic          rsp_valid_q, rsp_valid_d;
    logic [7:0]    rsp_data_q, rsp_data_d;
`endif

    // Phase sequencing and next bus output values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rwb_d     = rwb_q;
        ceb_d     = ceb_q;
        addr_d    = addr_q;
        bus_out_d = bus_out_q;
        launch_s  = 1'b0;
        pop_s     = 1'b0;
`ifdef SID_BUS_READ_EN
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
`endif
        case (state_q)
            ST_IDLE: begin
                launch_s = !empty_s;
            end
            ST_SETUP: begin
                if (cnt_q == PH_ONE) begin
                    state_d = ST_STROB;
                    cnt_d   = PH_STROB;
                    ceb_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - PH_ONE;
                end
            end
            ST_STROB: begin
                if (cnt_q == PH_ONE) begin
                    state_d = ST_HOLD;
                    cnt_d   = PH_HOLD;
                    ceb_d   = 1'b1;
                    rwb_d   = 1'b1;
`ifdef SID_BUS_READ_EN
                    if (rwb_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = bus_in;
                    end else begin
                        rsp_valid_d = 1'b0;
                        rsp_data_d  = rsp_data_q;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - PH_ONE;
                end
            end
            ST_HOLD: begin
                if (cnt_q == PH_ONE) begin
                    state_d  = ST_IDLE;
                    launch_s = !empty_s;
                end else begin
                    cnt_d = cnt_q - PH_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = PH_ZERO;
                ceb_d   = 1'b1;
                rwb_d   = 1'b1;
            end
        endcase

        // Starting a new command pops the FIFO; dropped reads leave the bus idle.
        if (launch_s) begin
            pop_s = 1'b1;
            if (head_skip_s) begin
                state_d = ST_IDLE;
            end else begin
                state_d   = ST_SETUP;
                cnt_d     = PH_SETUP;
                ceb_d     = 1'b1;
                rwb_d     = head_s[14];
                addr_d    = head_s[13:8];
                bus_out_d = head_s[7:0];
            end
        end else begin
            pop_s = 1'b0;
        end
    end

    // Sequencer state, phase counter and registered bus outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= PH_ZERO;
            rwb_q     <= 1'b1;
            ceb_q     <= 1'b1;
            addr_q    <= 6'h00;
            bus_out_q <= 8'h00;
`ifdef SID_BUS_READ_EN
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rwb_q     <= rwb_d;
            ceb_q     <= ceb_d;
            addr_q    <= addr_d;
            bus_out_q <= bus_out_d;
`ifdef SID_BUS_READ_EN
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
`endif
        end
    end

    assign cmd_ready = !full_s;
    assign busy      = (state_q != ST_IDLE) || !empty_s;
    assign RWb       = rwb_q;
    assign CEb       = ceb_q;
    assign reg_addr  = addr_q;
    assign bus_out   = bus_out_q;

`ifdef SID_BUS_READ_EN
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
`else
    logic unused_bus_in_s;
    assign unused_bus_in_s = ^bus_in;
    assign rsp_valid       = 1'b0;
    assign rsp_data        = 8'h00;
`endif

endmodule
